// File: rtl/decode_issue.sv
// decode_issue: RV32I decode/operand-fetch stage feeding the ALU through a one-entry output register.
// Define REGFILE_BYPASS_EN to forward same-edge writeback data into captured operands.
module decode_issue #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic [31:0]     instr_in,
    input  logic            instr_valid_in,
    output logic            instr_ready_out,
    input  logic            wb_en_in,
    input  logic [4:0]      wb_addr_in,
    input  logic [XLEN-1:0] wb_data_in,
    output logic [6:0]      opcode_out,
    output logic [2:0]      funct3_out,
    output logic [6:0]      funct7_out,
    output logic [XLEN-1:0] rs1_value_out,
    output logic [XLEN-1:0] mux_result_out,
    output logic [4:0]      rd_addr_out,
    output logic            illegal_out,
    output logic            dec_valid_out,
    input  logic            dec_ready_in,
    output logic [31:0]     issue_count_out
);
    localparam logic [6:0] OPC_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP  = 7'b0110011;

    logic [XLEN-1:0] rf_q [NREGS];

    logic            dec_valid_q;
    logic            illegal_q;
    logic [6:0]      opcode_q;
    logic [2:0]      funct3_q;
    logic [6:0]      funct7_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] rs1v_q;
    logic [XLEN-1:0] opb_q;
    logic [31:0]     cnt_q;

    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] rs1_d;
    logic [XLEN-1:0] opb_d;
    logic            is_imm;
    logic            is_op;
    logic            illegal_d;
    logic            accept;
    logic            issue;
    logic            wb_we;

    assign rs1    = instr_in[19:15];
    assign rs2    = instr_in[24:20];
    assign wb_we  = wb_en_in && (wb_addr_in != 5'd0);
    assign issue  = dec_valid_q && dec_ready_in;
    assign accept = instr_valid_in && instr_ready_out;

    assign instr_ready_out = !dec_valid_q || dec_ready_in;

    always_comb begin
        rs1_val = (rs1 == 5'd0) ? '0 : rf_q[rs1];
        rs2_val = (rs2 == 5'd0) ? '0 : rf_q[rs2];
`ifdef REGFILE_BYPASS_EN
        if (wb_we && wb_addr_in == rs1) rs1_val = wb_data_in;
        if (wb_we && wb_addr_in == rs2) rs2_val = wb_data_in;
`endif
    end

    // Illegal opcodes still issue, but with zeroed operands.
    always_comb begin
        is_imm    = instr_in[6:0] == OPC_IMM;
        is_op     = instr_in[6:0] == OPC_OP;
        illegal_d = !(is_imm || is_op);
        rs1_d     = '0;
        opb_d     = '0;
        unique case (1'b1)
            is_imm: begin
                rs1_d = rs1_val;
                opb_d = {{(XLEN-12){instr_in[31]}}, instr_in[31:20]};
            end
            is_op: begin
                rs1_d = rs1_val;
                opb_d = rs2_val;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            dec_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            opcode_q    <= '0;
            funct3_q    <= '0;
            funct7_q    <= '0;
            rd_q        <= '0;
            rs1v_q      <= '0;
            opb_q       <= '0;
            cnt_q       <= '0;
        end else begin
            if (issue) cnt_q <= cnt_q + 32'd1;
            if (accept) begin
                dec_valid_q <= 1'b1;
                illegal_q   <= illegal_d;
                opcode_q    <= instr_in[6:0];
                funct3_q    <= instr_in[14:12];
                funct7_q    <= instr_in[31:25];
                rd_q        <= instr_in[11:7];
                rs1v_q      <= rs1_d;
                opb_q       <= opb_d;
            end else if (issue) begin
                dec_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else if (wb_we) begin
            rf_q[wb_addr_in] <= wb_data_in;
        end
    end

    assign dec_valid_out   = dec_valid_q;
    assign illegal_out     = illegal_q;
    assign opcode_out      = opcode_q;
    assign funct3_out      = funct3_q;
    assign funct7_out      = funct7_q;
    assign rd_addr_out     = rd_q;
    assign rs1_value_out   = rs1v_q;
    assign mux_result_out  = opb_q;
    assign issue_count_out = cnt_q;
endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue: directed and randomized checks of decode_issue against a behavioural model.
// Build with REGFILE_BYPASS_EN to check the forwarding variant.
module tb_decode_issue;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] rs1_value;
    logic [31:0] mux_result;
    logic [4:0]  rd_addr;
    logic        illegal;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] issue_count;

    always #5 clk = ~clk;

    decode_issue dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .instr_in        (instr),
        .instr_valid_in  (instr_valid),
        .instr_ready_out (instr_ready),
        .wb_en_in        (wb_en),
        .wb_addr_in      (wb_addr),
        .wb_data_in      (wb_data),
        .opcode_out      (opcode),
        .funct3_out      (funct3),
        .funct7_out      (funct7),
        .rs1_value_out   (rs1_value),
        .mux_result_out  (mux_result),
        .rd_addr_out     (rd_addr),
        .illegal_out     (illegal),
        .dec_valid_out   (dec_valid),
        .dec_ready_in    (dec_ready),
        .issue_count_out (issue_count)
    );

    int checks = 0;
    int failures = 0;

    // Reference state: architectural registers plus the expected output slot.
    logic [31:0] regs [32];
    logic [31:0] m_ins;
    logic        m_valid;
    logic [31:0] m_rs1v;
    logic [31:0] m_mux;
    logic        m_ill;
    logic [31:0] m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] read_reg(input logic [4:0] idx);
        if (idx == 0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
        if (wb_en && wb_addr == idx) return wb_data;
`endif
        return regs[idx];
    endfunction

    task automatic chk_all();
        chk("dec_valid", 32'(dec_valid), 32'(m_valid));
        chk("illegal", 32'(illegal), 32'(m_ill));
        chk("opcode", 32'(opcode), 32'(m_ins[6:0]));
        chk("funct3", 32'(funct3), 32'(m_ins[14:12]));
        chk("funct7", 32'(funct7), 32'(m_ins[31:25]));
        chk("rd", 32'(rd_addr), 32'(m_ins[11:7]));
        chk("rs1_value", rs1_value, m_rs1v);
        chk("mux_result", mux_result, m_mux);
        chk("issue_count", issue_count, m_cnt);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        m_ins = 0; m_valid = 0; m_rs1v = 0; m_mux = 0; m_ill = 0; m_cnt = 0;
    endtask

    task automatic cycle();
        logic rdy, acc, iss;
        logic [6:0] op;
        #1;
        rdy = !m_valid || dec_ready;
        chk("instr_ready", 32'(instr_ready), 32'(rdy));
        acc = instr_valid && rdy;
        iss = m_valid && dec_ready;
        if (iss) m_cnt = m_cnt + 1;
        if (acc) begin
            op = instr[6:0];
            m_ins   = instr;
            m_valid = 1;
            m_ill   = 1;
            m_rs1v  = 0;
            m_mux   = 0;
            if (op == 7'h13) begin
                m_ill  = 0;
                m_rs1v = read_reg(instr[19:15]);
                m_mux  = 32'($signed(instr[31:20]));
            end else if (op == 7'h33) begin
                m_ill  = 0;
                m_rs1v = read_reg(instr[19:15]);
                m_mux  = read_reg(instr[24:20]);
            end
        end else if (iss) begin
            m_valid = 0;
        end
        if (wb_en && wb_addr != 0) regs[wb_addr] = wb_data;
        @(posedge clk);
        #1;
        chk_all();
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic r,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd);
        instr_valid = v; instr = ins; dec_ready = r;
        wb_en = we; wb_addr = wa; wb_data = wd;
        cycle();
    endtask

    task automatic do_reset();
        #1 rst_n = 0;
        #1;
        model_reset();
        chk_all();
        chk("reset_ready", 32'(instr_ready), 32'd1);
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        logic [31:0] r;
        rst_n = 0; instr = 0; instr_valid = 0; dec_ready = 0;
        wb_en = 0; wb_addr = 0; wb_data = 0;
        model_reset();
        #2;
        chk_all();
        chk("reset_ready", 32'(instr_ready), 32'd1);
        #10 rst_n = 1;

        drive(0, 32'h0, 1, 1, 5'd5, 32'h10);
        drive(1, 32'hFFF28313, 1, 0, 0, 0);
        chk("addi_mux", mux_result, 32'hFFFFFFFF);
        chk("addi_rs1", rs1_value, 32'h10);
        drive(1, 32'h4032D393, 1, 0, 0, 0);
        chk("srai_mux", mux_result, 32'h403);
        drive(0, 32'h0, 1, 1, 5'd6, 32'h20);
        drive(1, 32'h00628433, 1, 0, 0, 0);
        chk("add_mux", mux_result, 32'h20);

        for (int i = 0; i < 3; i++) drive(1, 32'hFFF28313, 0, 0, 0, 0);
        drive(1, 32'h4032D393, 1, 0, 0, 0);
        drive(1, 32'h00628433, 1, 0, 0, 0);
        drive(0, 32'h0, 1, 0, 0, 0);

        drive(1, 32'h00628433, 1, 1, 5'd5, 32'hAAAA0000);
`ifdef REGFILE_BYPASS_EN
        chk("same_edge_rs1", rs1_value, 32'hAAAA0000);
`else
        chk("same_edge_rs1", rs1_value, 32'h10);
`endif
        drive(1, 32'h00000073, 1, 0, 0, 0);
        chk("ecall_illegal", 32'(illegal), 32'd1);
        drive(0, 32'h0, 1, 1, 5'd0, 32'hFFFFFFFF);
        drive(1, 32'h00500093, 1, 0, 0, 0);
        chk("x0_reads_zero", rs1_value, 32'h0);

        @(posedge clk);
        do_reset();
        drive(1, 32'hFFF28313, 1, 0, 0, 0);
        chk("x5_after_reset", rs1_value, 32'h0);

        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            case ($urandom_range(0, 3))
                0, 1: instr = {r[31:7], 7'b0010011};
                2: instr = {r[31:7], 7'b0110011};
                default: instr = r;
            endcase
            instr_valid = ($urandom_range(0, 9) < 7);
            dec_ready   = ($urandom_range(0, 9) < 7);
            wb_en       = $urandom_range(0, 1) == 1;
            wb_addr     = 5'($urandom_range(0, 31));
            wb_data     = $urandom;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/decode_issue.md
Name: decode_issue

Overview:
- Pipelined decode/operand-fetch stage; the producer side of the ALU interface.
- Accepts 32-bit RV32I instructions from fetch over a valid/ready handshake and splits out opcode, funct3 and funct7.
- Reads operands from an internal 32x32 register file and forms the second operand: sign-extended immediate for OP-IMM, rs2 value for OP.
- Presents the result to the ALU through a one-entry output register with its own valid/ready handshake. A writeback port updates the register file.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.
- NREGS, 32, number of architectural registers. Address width is log2(NREGS) = 5.

Ports:
- clk_in  in  1  system clock, rising edge
- rst_n_in  in  1  asynchronous active-low reset
- instr_in  in  32  instruction word from fetch
- instr_valid_in  in  1  instr_in is valid
- instr_ready_out  out  1  stage can accept an instruction this cycle
- wb_en_in  in  1  register-file write enable
- wb_addr_in  in  5  write register index
- wb_data_in  in  32  write data
- opcode_out  out  7  instr[6:0]
- funct3_out  out  3  instr[14:12]
- funct7_out  out  7  instr[31:25]
- rs1_value_out  out  32  register value for rs1
- mux_result_out  out  32  second ALU operand
- rd_addr_out  out  5  instr[11:7]
- illegal_out  out  1  opcode is neither 0010011 nor 0110011
- dec_valid_out  out  1  output register holds a decoded instruction
- dec_ready_in  in  1  ALU side accepts the output this cycle
- issue_count_out  out  32  number of output handshakes completed

Behaviour:
- Reset (rst_n_in low, asynchronous):
  - dec_valid_out=0, illegal_out=0, issue_count_out=0.
  - All data outputs and all register-file entries = 0.
  - Any in-flight instruction is discarded. Normal operation resumes on the first rising edge after deassertion.
- Handshake rules:
  - instr_ready_out = !dec_valid_out || dec_ready_in (combinational).
  - Accept: instr_valid_in && instr_ready_out at the rising edge. All outputs load on that edge and dec_valid_out=1. Latency is 1 cycle from accept to dec_valid_out.
  - Output handshake: dec_valid_out && dec_ready_in. On that edge issue_count_out increments by 1 and wraps 0xFFFFFFFF -> 0.
  - If the output handshake completes and there is no new accept on the same edge, dec_valid_out -> 0.
  - If both happen on the same edge, the new instruction replaces the old one with no bubble.
  - Back-pressure: while dec_valid_out=1 and dec_ready_in=0, all outputs hold stable and instr_ready_out=0.
- Operand rules:
  - rs1 = instr[19:15], rs2 = instr[24:20]. Register x0 always reads 0; writes to x0 are ignored.
  - OP-IMM (0010011): mux_result = sign-extend(instr[31:20]) for every funct3. For shifts, bits [11:5] are therefore the raw funct7 image: SRAI gives 0x400|shamt, SLLI/SRLI give shamt.
  - OP (0110011): mux_result = value of rs2.
  - Any other opcode: illegal_out=1, rs1_value_out=0, mux_result_out=0. All fields still pass through and the instruction is still issued.
- Register file:
  - Written on the rising edge when wb_en_in=1 and wb_addr_in!=0. Writeback is independent of both handshakes.
  - Operands are sampled only at accept. A later writeback never changes operands already held in the output register.
- Same-cycle write and read of the same register: behaviour depends on REGFILE_BYPASS_EN (next section).

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: if wb_en_in=1, wb_addr_in!=0 and wb_addr_in matches rs1 or rs2 on the accept edge, the captured operand is wb_data_in (write-through forwarding).
- Undefined: the captured operand is the pre-write register value. The new value is visible to instructions accepted on later edges.

Test Plan:
- Reset then idle: rst_n_in low mid-run -> dec_valid_out=0, issue_count_out=0, instr_ready_out=1, and x5 reads 0 afterwards.
- Write x5=0x00000010, then accept 0xFFF28313 (addi x6,x5,-1) -> next cycle: opcode 0010011, funct3 000, rs1_value 0x00000010, mux_result 0xFFFFFFFF, rd 6, illegal 0.
- With x5=0x10, accept 0x4032D393 (srai x7,x5,3) -> funct3 101, mux_result 0x00000403. Write x6=0x20, accept 0x00628433 (add x8,x5,x6) -> opcode 0110011, funct7 0, mux_result 0x00000020.
- Hold dec_ready_in=0 for 3 cycles with instr_valid_in=1 -> outputs stable, instr_ready_out=0, count unchanged. Then dec_ready_in=1 for 2 back-to-back instructions -> no bubble, issue_count_out +2.
- Accept add x8,x5,x6 on the same edge as wb x5=0xAAAA0000 (x5 previously 0x10) -> rs1_value_out 0xAAAA0000 with REGFILE_BYPASS_EN defined, 0x00000010 without it.
- Accept 0x00000073 -> illegal_out=1, opcode 1110011, rs1_value 0, mux_result 0, dec_valid_out=1. Write to x0 with 0xFFFFFFFF -> x0 still reads 0.
